// File: rtl/dff.sv
//------------------------------------------------------------------------------
// Module      : dff
// Description : Synchronous-reset D register with a parameterised number of
//               cascaded stages; Q is taken straight from the last stage flop.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module dff #(
    parameter int unsigned          WIDTH       = 1,
    parameter logic [WIDTH-1:0]     RESET_VALUE = {WIDTH{1'b0}},
    parameter int unsigned          STAGES      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    localparam int unsigned C_MIN_STAGES = 1;
    localparam int unsigned C_MAX_STAGES = 16;

    generate
        if (STAGES < C_MIN_STAGES || STAGES > C_MAX_STAGES) begin : g_bad_stages
            $error("dff: STAGES=%0d outside legal range 1..16", STAGES);
        end
    endgenerate

    logic [WIDTH-1:0] r_stage [STAGES];

    // Every stage owns its own flop so reset clears all in-flight data at once.
    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_stage[k] <= RESET_VALUE;
                    end else begin
                        r_stage[k] <= D;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_stage[k] <= RESET_VALUE;
                    end else begin
                        r_stage[k] <= r_stage[k-1];
                    end
                end
            end
        end
    endgenerate

    assign Q = r_stage[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_dff.sv
//------------------------------------------------------------------------------
// Module      : tb_dff
// Description : Directed bench for dff across default, 8-bit and 3-stage builds.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_dff;

    logic       clk = 1'b0;
    logic       rst1, d1, q1;
    logic       rst8;
    logic [7:0] d8, q8;
    logic       rst3, d3, q3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dff u_dff1 (
        .clk (clk),
        .rst (rst1),
        .D   (d1),
        .Q   (q1)
    );

    dff #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5),
        .STAGES      (1)
    ) u_dff8 (
        .clk (clk),
        .rst (rst8),
        .D   (d8),
        .Q   (q8)
    );

    dff #(
        .WIDTH  (1),
        .STAGES (3)
    ) u_dff3 (
        .clk (clk),
        .rst (rst3),
        .D   (d3),
        .Q   (q3)
    );

    task automatic at(input longint t);
        if ($time < t) #(t - $time);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst1 = 1'b1; d1 = 1'b0;
        rst8 = 1'b1; d8 = 8'h3C;
        rst3 = 1'b1; d3 = 1'b0;

        at(10);
        chk("w1_reset",     {7'd0, q1}, 8'h00);
        chk("w8_reset",     q8,         8'hA5);
        chk("s3_reset",     {7'd0, q3}, 8'h00);
        rst1 = 1'b0; rst8 = 1'b0; rst3 = 1'b0; d3 = 1'b1;

        at(16);
        chk("w8_capture",   q8,         8'h3C);

        at(20);
        chk("w1_hold",      {7'd0, q1}, 8'h00);
        d1 = 1'b1; d8 = 8'h5A;

        at(24);
        chk("w1_between",   {7'd0, q1}, 8'h00);

        at(26);
        chk("w1_cap1",      {7'd0, q1}, 8'h01);
        chk("w8_cap2",      q8,         8'h5A);
        chk("s3_lat_e1",    {7'd0, q3}, 8'h00);

        at(30);
        d1 = 1'b0;

        at(36);
        chk("w1_cap0",      {7'd0, q1}, 8'h00);
        chk("s3_lat_e2",    {7'd0, q3}, 8'h01);

        at(40);
        d1 = 1'b1; rst3 = 1'b1;

        at(46);
        chk("w1_cap1b",     {7'd0, q1}, 8'h01);
        chk("s3_rst",       {7'd0, q3}, 8'h00);

        at(50);
        rst1 = 1'b1; rst3 = 1'b0;

        at(54);
        chk("w1_rst_sync",  {7'd0, q1}, 8'h01);

        at(56);
        chk("w1_rst_prio",  {7'd0, q1}, 8'h00);
        chk("s3_post_e1",   {7'd0, q3}, 8'h00);

        at(60);
        rst1 = 1'b0;

        at(66);
        chk("w1_after_rst", {7'd0, q1}, 8'h01);
        chk("s3_post_e2",   {7'd0, q3}, 8'h00);

        at(70);
        d1 = 1'b0;

        at(76);
        chk("w1_cap0b",     {7'd0, q1}, 8'h00);
        chk("s3_post_e3",   {7'd0, q3}, 8'h01);

        at(80);
        d1 = 1'b1; d3 = 1'b0;

        at(86);
        chk("w1_cap1c",     {7'd0, q1}, 8'h01);
        chk("s3_drain",     {7'd0, q3}, 8'h01);

        at(91);
        rst1 = 1'b1;
        at(94);
        rst1 = 1'b0;
        chk("w1_pulse_mid", {7'd0, q1}, 8'h01);

        at(96);
        chk("w1_pulse_aft", {7'd0, q1}, 8'h01);

        at(100);
        d3 = 1'b1;

        at(106);
        chk("s3_empty",     {7'd0, q3}, 8'h00);

        at(110);
        rst3 = 1'b1;

        at(116);
        chk("s3_inflight",  {7'd0, q3}, 8'h00);

        at(120);
        rst3 = 1'b0;

        at(126);
        chk("s3_rel_e1",    {7'd0, q3}, 8'h00);
        at(136);
        chk("s3_rel_e2",    {7'd0, q3}, 8'h00);
        at(146);
        chk("s3_rel_e3",    {7'd0, q3}, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
